rou_multiwriter: RTL
====================

// Module: rou_multiwriter
// PURPOSE
//  Write-side counterpart of the local-memory multi-reader. Accepts one command (start
//  address, access size, byte count, increment flag) and a packed byte stream of up to
//  16 bytes per beat. Re-aligns the stream into memory-width accesses with byte strobes
//  and issues them on the local memory write port. Sits between a stream producer and
//  the local memory.
// PARAMETERS
//  BUFBYTES  32  staging buffer depth in bytes; must be >= 32
// PORTS
//  clk             in   1    single clock, all logic on posedge
//  rst             in   1    synchronous reset, active high
//  start_addr      in   32   first byte address
//  memsize         in   3    access width W = 1<<memsize bytes; 0..4 legal, 5..7 act as 4
//  bytes           in   20   total bytes to write
//  incr_addr       in   1    1: address advances by W per access; 0: fixed word address
//  valid           in   1    command strobe; taken only when !busy
//  busy            out  1    command in progress
//  done            out  1    one-cycle pulse after the final write transfers
//  err             out  1    one-cycle pulse when input bytes exceed the command count
//  idata           in   128  stream data; byte k in idata[8k+7:8k]
//  ibytes          in   5    valid bytes in idata, 1..16, LSB-packed
//  ivalid          in   1    stream beat present
//  itaken          out  1    beat consumed this cycle (combinational)
//  local_wr        out  1    write request
//  local_wr_addr   out  32   W-aligned word address
//  local_wr_data   out  128  data, placed on lanes matching the strobes
//  local_wr_strb   out  16   byte enables
//  local_wr_ok     in   1    request accepted; a transfer is local_wr && local_wr_ok
// BEHAVIOUR
//  - Reset: busy, done, err, itaken, local_wr = 0; local_wr_addr, local_wr_data,
//    local_wr_strb = 0. The staging buffer, counters and any partial command are dropped.
//  - Command: if valid && !busy && bytes != 0, latch W, the aligned address
//    start_addr & ~(W-1), off = start_addr & (W-1), rem_wr = bytes and rem_in = bytes.
//    busy rises next cycle. If bytes == 0, no write is issued, busy stays 0, and done
//    pulses the next cycle. A valid seen while busy is ignored.
//  - Chunk size: need = min(W-off, rem_wr) for the first access, then min(W, rem_wr).
//    off is cleared after the first transfer.
//  - Input accept: itaken = busy && ivalid && (cnt + min(ibytes, rem_in) <= BUFBYTES).
//    cnt is the fill level before this cycle's consume. Bytes are appended at buffer
//    position cnt.
//  - Overrun: if ibytes > rem_in, only rem_in bytes are kept, the beat is still taken,
//    and err pulses. A beat arriving after rem_in == 0 is taken, discarded, and pulses err.
//  - Write request: local_wr = busy && cnt >= need && rem_wr != 0.
//    strb = ((1<<need)-1) << off.
//    data = buffer low bytes << (8*off); lanes without a strobe bit are don't-care (drive 0).
//  - A request stays asserted with addr/data/strb stable until local_wr_ok.
//    There is no combinational path from local_wr_ok to local_wr.
//  - On transfer: drop need bytes from the buffer head, rem_wr -= need, and
//    addr += W if incr_addr (wraps mod 2^32), else addr is unchanged.
//  - Same cycle append + consume: cnt_next = cnt + appended - need.
//    The appended data lands after the consumed bytes are removed.
//  - Latency: a beat taken in cycle N can back a local_wr in cycle N+1 at the earliest.
//    Throughput is one W-byte write per cycle when the stream supplies >= W bytes per beat.
//  - Completion: the transfer that makes rem_wr == 0 clears busy next cycle, with done
//    pulsing in that cycle. A new command is accepted the cycle busy is low.
// TESTING
//  1 memsize=4, start 0x1004, bytes 40, incr=1, beats of 16/16/8 -> writes
//    0x1000 strb 0xFFF0, then 0x1010 strb 0xFFFF, then 0x1020 strb 0x0FFF;
//    done pulses once; data bytes 0..39 appear in order.
//  2 memsize=2, start 0x203, bytes 6, incr=0, one 6-byte beat -> three writes at 0x200,
//    strb 0x8, 0xF, 0x1; stream byte0 on lane 3.
//  3 Case 1 with local_wr_ok held low 5 cycles -> addr/data/strb stable throughout;
//    itaken drops once cnt + ibytes > 32; no byte lost or duplicated.
//  4 bytes=10, one 16-byte beat -> itaken=1, err pulses, single write of 10 bytes;
//    a further beat -> taken, err pulses again.
//  5 bytes=0 -> no local_wr, busy stays 0, done pulses; valid while busy is ignored;
//    rst mid-command -> all outputs 0 next cycle and a fresh command completes normally.
//  6 Random memsize/start/bytes/ibytes with random local_wr_ok stalls,
//    checked against a byte-addressed memory model.

Source files
------------

// File: rtl/rou_multiwriter.sv
`default_nettype none
// ============================================================================
// Module   : rou_multiwriter
// Brief    : Re-aligns a packed byte stream into W-byte local-memory writes
//            with byte strobes, starting at an arbitrary byte address.
// Revision : 1.0 - initial release
// ============================================================================
module rou_multiwriter #(
    parameter int BUFBYTES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  start_addr,
    input  logic [2:0]   memsize,
    input  logic [19:0]  bytes,
    input  logic         incr_addr,
    input  logic         valid,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic [127:0] idata,
    input  logic [4:0]   ibytes,
    input  logic         ivalid,
    output logic         itaken,
    output logic         local_wr,
    output logic [31:0]  local_wr_addr,
    output logic [127:0] local_wr_data,
    output logic [15:0]  local_wr_strb,
    input  logic         local_wr_ok
);

    localparam int c_CW = $clog2(BUFBYTES + 1);
    localparam int c_BW = BUFBYTES * 8;

    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_incr;
    logic [4:0]      r_w;
    logic [3:0]      r_off;
    logic [31:0]     r_addr;
    logic [19:0]     r_rem_wr;
    logic [19:0]     r_rem_in;
    logic [c_CW-1:0] r_cnt;
    logic [c_BW-1:0] r_buf;

    // Command decode: memsize 5..7 behaves as 16-byte accesses
    logic [2:0]  w_msz;
    logic [4:0]  w_cmd_w;
    logic [31:0] w_cmd_mask;

    assign w_msz      = (memsize > 3'd4) ? 3'd4 : memsize;
    assign w_cmd_w    = 5'd1 << w_msz;
    assign w_cmd_mask = {27'd0, w_cmd_w} - 32'd1;

    // Chunk size; r_off is nonzero only before the first transfer
    logic [4:0] w_room;
    logic [4:0] w_need;
    logic       w_wr;
    logic       w_xfer;

    assign w_room = r_w - {1'b0, r_off};
    assign w_need = (r_rem_wr < {15'd0, w_room}) ? r_rem_wr[4:0] : w_room;
    assign w_wr   = r_busy && (32'(r_cnt) >= 32'(w_need)) && (r_rem_wr != 20'd0);
    assign w_xfer = w_wr && local_wr_ok;

    // Request payload, derived only from registered state so it holds while stalled
    logic [15:0]  w_strb_raw;
    logic [15:0]  w_strb;
    logic [127:0] w_head;
    logic [127:0] w_lane_mask;

    assign w_strb_raw = 16'(((32'd1 << w_need) - 32'd1) << r_off);
    assign w_strb     = w_wr ? w_strb_raw : 16'd0;
    assign w_head     = r_buf[127:0] << (8 * int'(r_off));

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_lane
            assign w_lane_mask[8*g +: 8] = {8{w_strb[g]}};
        end
    endgenerate

    // Input accept: bytes beyond the command count are swallowed
    logic         w_over;
    logic [4:0]   w_app;
    logic [4:0]   w_app_eff;
    logic [4:0]   w_cons;
    logic         w_itaken;
    logic [127:0] w_in_keep;
    logic [c_BW-1:0] w_buf_next;
    logic [c_CW-1:0] w_cnt_next;

    assign w_over    = ({15'd0, ibytes} > r_rem_in);
    assign w_app     = w_over ? r_rem_in[4:0] : ibytes;
    assign w_itaken  = r_busy && ivalid && ((32'(r_cnt) + 32'(w_app)) <= 32'(BUFBYTES));
    assign w_app_eff = w_itaken ? w_app : 5'd0;
    assign w_cons    = w_xfer ? w_need : 5'd0;
    assign w_in_keep = idata & ((128'd1 << (8 * int'(w_app_eff))) - 128'd1);

    // Bytes above r_cnt are always zero, so the append can be OR-ed in
    assign w_buf_next = (r_buf >> (8 * int'(w_cons)))
                      | (c_BW'(w_in_keep) << (8 * (int'(r_cnt) - int'(w_cons))));
    assign w_cnt_next = c_CW'(int'(r_cnt) - int'(w_cons) + int'(w_app_eff));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_incr   <= 1'b0;
            r_w      <= 5'd0;
            r_off    <= 4'd0;
            r_addr   <= 32'd0;
            r_rem_wr <= 20'd0;
            r_rem_in <= 20'd0;
            r_cnt    <= '0;
            r_buf    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_itaken && w_over;
            if (!r_busy) begin
                if (valid) begin
                    if (bytes != 20'd0) begin
                        r_busy   <= 1'b1;
                        r_w      <= w_cmd_w;
                        r_off    <= start_addr[3:0] & w_cmd_mask[3:0];
                        r_addr   <= start_addr & ~w_cmd_mask;
                        r_rem_wr <= bytes;
                        r_rem_in <= bytes;
                        r_incr   <= incr_addr;
                        r_cnt    <= '0;
                        r_buf    <= '0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else begin
                r_cnt    <= w_cnt_next;
                r_buf    <= w_buf_next;
                r_rem_in <= r_rem_in - {15'd0, w_app_eff};
                if (w_xfer) begin
                    r_rem_wr <= r_rem_wr - {15'd0, w_need};
                    r_off    <= 4'd0;
                    if (r_incr) begin
                        r_addr <= r_addr + {27'd0, r_w};
                    end
                    if (r_rem_wr == {15'd0, w_need}) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign itaken        = w_itaken;
    assign local_wr      = w_wr;
    assign local_wr_addr = r_addr;
    assign local_wr_strb = w_strb;
    assign local_wr_data = w_head & w_lane_mask;

endmodule
`default_nettype wire
